// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit teaching RISC CPU.
// Used by the controller, the ALU and the IR decode.
package risc_pkg;

  localparam int OPCODE_W = 3;

  // Opcodes
  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  // Instruction-cycle phases
  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  // Opcodes that read an operand from memory into the accumulator
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath strobe bundle.
// Optional macro RISC_CTRL_RESUME_EN adds the resume input.
interface risc_controller_if;
  import risc_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic [2:0]          phase;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                halt;
  logic                inc_pc;
  logic                ld_ac;
  logic                ld_pc;
  logic                wr;
  logic                data_e;
`ifdef RISC_CTRL_RESUME_EN
  logic                resume;
`endif

  // Controller side
  modport master (
    input  opcode, zero,
`ifdef RISC_CTRL_RESUME_EN
    input  resume,
`endif
    output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

  // Datapath side
  modport slave (
    output opcode, zero,
`ifdef RISC_CTRL_RESUME_EN
    output resume,
`endif
    input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
  );

endinterface

// File: rtl/risc_phase_counter.sv
// 3-bit instruction-phase counter: free-running wrap 7->0,
// with hold (halted) and load-to-zero (resume). rst has priority.
module risc_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hold,
  input  logic       i_clear,
  output logic [2:0] o_phase
);

  logic [2:0] r_phase;

  // Advance one phase per clock unless held; clear restarts the cycle
  always_ff @(posedge clk) begin
    if (rst)          r_phase <= 3'd0;
    else if (i_clear) r_phase <= 3'd0;
    else if (!i_hold) r_phase <= r_phase + 3'd1;
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/risc_controller.sv
// Sequencer for the 8-bit teaching RISC CPU: 8-phase instruction cycle,
// opcode/zero decode into per-phase control strobes.
// Optional macro RISC_CTRL_RESUME_EN: resume input clears a halt.
module risc_controller #(
  parameter int NUM_PHASES = 8,
  parameter int OPCODE_W   = risc_pkg::OPCODE_W
) (
  input  logic             clk,
  input  logic             rst,
  risc_controller_if.master bus
);

  // The phase decode below is written for exactly 8 phases
  if (NUM_PHASES != 8) begin : g_bad_phases
    $error("risc_controller: NUM_PHASES must be 8");
  end
  if (OPCODE_W != risc_pkg::OPCODE_W) begin : g_bad_opw
    $error("risc_controller: OPCODE_W must match risc_pkg::OPCODE_W");
  end

  logic [2:0] w_phase;
  logic       r_halted;
  logic       w_set_halt;
  logic       w_resume_go;
  logic       w_aluop;
  logic       w_is_hlt, w_is_skz, w_is_sto, w_is_jmp;

  assign w_aluop  = risc_pkg::is_aluop(bus.opcode);
  assign w_is_hlt = (bus.opcode == risc_pkg::HLT);
  assign w_is_skz = (bus.opcode == risc_pkg::SKZ);
  assign w_is_sto = (bus.opcode == risc_pkg::STO);
  assign w_is_jmp = (bus.opcode == risc_pkg::JMP);

  // HLT is taken at the end of OP_ADDR; the phase must not advance past it
  assign w_set_halt = !r_halted && (w_phase == risc_pkg::OP_ADDR) && w_is_hlt;

`ifdef RISC_CTRL_RESUME_EN
  assign w_resume_go = r_halted && bus.resume;
`else
  assign w_resume_go = 1'b0;
`endif

  risc_phase_counter u_phase (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (r_halted || w_set_halt),
    .i_clear (w_resume_go),
    .o_phase (w_phase)
  );

  // Halted flag: set by HLT, cleared only by rst or resume
  always_ff @(posedge clk) begin
    if (rst)              r_halted <= 1'b0;
    else if (w_resume_go) r_halted <= 1'b0;
    else if (w_set_halt)  r_halted <= 1'b1;
  end

  logic w_sel, w_rd, w_ld_ir, w_halt, w_inc_pc, w_ld_ac, w_ld_pc, w_wr, w_data_e;

  // Strobe decode from registered phase/halted plus current opcode/zero
  always_comb begin
    w_sel    = 1'b0;
    w_rd     = 1'b0;
    w_ld_ir  = 1'b0;
    w_halt   = 1'b0;
    w_inc_pc = 1'b0;
    w_ld_ac  = 1'b0;
    w_ld_pc  = 1'b0;
    w_wr     = 1'b0;
    w_data_e = 1'b0;
    if (r_halted) begin
      w_halt = 1'b1;
    end else begin
      case (w_phase)
        risc_pkg::INST_ADDR: w_sel = 1'b1;
        risc_pkg::INST_FETCH: begin
          w_sel = 1'b1;
          w_rd  = 1'b1;
        end
        risc_pkg::INST_LOAD, risc_pkg::IDLE: begin
          w_sel   = 1'b1;
          w_rd    = 1'b1;
          w_ld_ir = 1'b1;
        end
        risc_pkg::OP_ADDR: begin
          w_halt   = w_is_hlt;
          w_inc_pc = 1'b1;
        end
        risc_pkg::OP_FETCH: w_rd = w_aluop;
        risc_pkg::ALU_OP: begin
          w_rd     = w_aluop;
          w_inc_pc = w_is_skz && bus.zero;
          w_ld_pc  = w_is_jmp;
          // Drive the bus one phase ahead of wr for setup time
          w_data_e = w_is_sto;
        end
        default: begin // STORE
          w_rd     = w_aluop;
          w_ld_ac  = w_aluop;
          w_ld_pc  = w_is_jmp;
          w_wr     = w_is_sto;
          w_data_e = w_is_sto;
        end
      endcase
    end
  end

  assign bus.phase  = w_phase;
  assign bus.sel    = w_sel;
  assign bus.rd     = w_rd;
  assign bus.ld_ir  = w_ld_ir;
  assign bus.halt   = w_halt;
  assign bus.inc_pc = w_inc_pc;
  assign bus.ld_ac  = w_ld_ac;
  assign bus.ld_pc  = w_ld_pc;
  assign bus.wr     = w_wr;
  assign bus.data_e = w_data_e;

endmodule
